// File: rtl/alu_mat_driver.sv
// Command-level initiator for the 3x3 matrix ALU: loads operands through the
// sel/eleIn port, fires the op, then streams results out on a valid/ready bus.
module alu_mat_driver #(
  parameter int DATA_W   = 32,
  parameter int SEL_W    = 6,
  parameter int IDLE_SEL = 27,
  parameter int C_SEL    = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  output logic              cmd_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [SEL_W-1:0]  alu_sel,
  output logic [DATA_W-1:0] alu_eleIn,
  input  logic [DATA_W-1:0] alu_eleOut,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_E, S_LOAD_F, S_LOAD_C, S_EXEC, S_SETTLE, S_RD_SEL, S_RD_OUT
  } state_t;

  typedef enum logic [2:0] {
    OP_TRN, OP_ADD, OP_SUB, OP_MUL, OP_SCL, OP_DET, OP_BAD6, OP_BAD7
  } op_t;

  localparam logic [SEL_W-1:0] L_IDLE   = SEL_W'(IDLE_SEL);
  localparam logic [SEL_W-1:0] L_CSEL   = SEL_W'(C_SEL);
  localparam logic [SEL_W-1:0] L_F0     = SEL_W'(9);
  localparam logic [SEL_W-1:0] L_RD0    = SEL_W'(18);
  localparam logic [SEL_W-1:0] L_RD_DET = SEL_W'(27);
  localparam logic [SEL_W-1:0] L_EXEC0  = SEL_W'(28);

  state_t              r_state, w_state_n;
  op_t                 r_op, w_op_n;
  logic [3:0]          r_cnt, w_cnt_n;
  logic [3:0]          r_k, w_k_n;
  logic [SEL_W-1:0]    r_alu_sel, w_sel_n;
  logic [DATA_W-1:0]   r_alu_eleIn, w_eleIn_n;
  logic                r_out_valid, w_ov_n;
  logic [DATA_W-1:0]   r_out_data, w_od_n;
  logic                r_out_last, w_ol_n;
  logic                r_cmd_err, w_err_n;

  logic                w_in_ready;
  logic                w_in_hs;
  logic                w_legal;
  logic                w_last;
  logic [SEL_W-1:0]    w_exec_sel;

  function automatic logic [SEL_W-1:0] rd_code(input op_t op, input logic [3:0] k);
    return (op == OP_DET) ? L_RD_DET : L_RD0 + SEL_W'(k);
  endfunction

  assign w_in_ready = (((r_state == S_LOAD_E) || (r_state == S_LOAD_F)) && (r_cnt < 4'd9)) ||
                      ((r_state == S_LOAD_C) && (r_cnt == 4'd0));
  assign w_in_hs    = w_in_ready & in_valid;
  assign w_legal    = (cmd_op < 3'd6);
  assign w_last     = (r_op == OP_DET) ? (r_k == 4'd0) : (r_k == 4'd8);
  assign w_exec_sel = L_EXEC0 + SEL_W'(r_op);

  // Loads register the word in the cycle after its handshake, so each LOAD
  // state lingers one extra cycle (cnt at full, in_ready low) before moving on;
  // this gives the t -> EXEC at t+2 timing after the final operand.
  always_comb begin
    w_state_n = r_state;
    w_op_n    = r_op;
    w_cnt_n   = r_cnt;
    w_k_n     = r_k;
    w_sel_n   = L_IDLE;
    w_eleIn_n = r_alu_eleIn;
    w_ov_n    = r_out_valid;
    w_od_n    = r_out_data;
    w_ol_n    = r_out_last;
    w_err_n   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (w_legal) begin
            w_state_n = S_LOAD_E;
            w_op_n    = op_t'(cmd_op);
            w_cnt_n   = '0;
            w_k_n     = '0;
          end else begin
            w_err_n = 1'b1;
          end
        end
      end
      S_LOAD_E: begin
        if (w_in_hs) begin
          w_sel_n   = SEL_W'(r_cnt);
          w_eleIn_n = in_data;
          w_cnt_n   = r_cnt + 4'd1;
        end else if (r_cnt == 4'd9) begin
          w_cnt_n = '0;
          case (r_op)
            OP_ADD, OP_SUB, OP_MUL: w_state_n = S_LOAD_F;
            OP_SCL:                 w_state_n = S_LOAD_C;
            default: begin
              w_state_n = S_EXEC;
              w_sel_n   = w_exec_sel;
            end
          endcase
        end
      end
      S_LOAD_F: begin
        if (w_in_hs) begin
          w_sel_n   = L_F0 + SEL_W'(r_cnt);
          w_eleIn_n = in_data;
          w_cnt_n   = r_cnt + 4'd1;
        end else if (r_cnt == 4'd9) begin
          w_cnt_n   = '0;
          w_state_n = S_EXEC;
          w_sel_n   = w_exec_sel;
        end
      end
      S_LOAD_C: begin
        if (w_in_hs) begin
          w_sel_n   = L_CSEL;
          w_eleIn_n = in_data;
          w_cnt_n   = r_cnt + 4'd1;
        end else if (r_cnt == 4'd1) begin
          w_cnt_n   = '0;
          w_state_n = S_EXEC;
          w_sel_n   = w_exec_sel;
        end
      end
      S_EXEC:   w_state_n = S_SETTLE;
      S_SETTLE: begin
        w_state_n = S_RD_SEL;
        w_sel_n   = rd_code(r_op, r_k);
      end
      S_RD_SEL: begin
        w_state_n = S_RD_OUT;
        w_ov_n    = 1'b1;
        w_od_n    = alu_eleOut;
        w_ol_n    = w_last;
      end
      S_RD_OUT: begin
        if (out_ready) begin
          w_ov_n = 1'b0;
          w_ol_n = 1'b0;
          if (w_last) begin
            w_state_n = S_IDLE;
            w_k_n     = '0;
          end else begin
            w_state_n = S_RD_SEL;
            w_k_n     = r_k + 4'd1;
            w_sel_n   = rd_code(r_op, r_k + 4'd1);
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= OP_TRN;
      r_cnt       <= '0;
      r_k         <= '0;
      r_alu_sel   <= L_IDLE;
      r_alu_eleIn <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_op        <= w_op_n;
      r_cnt       <= w_cnt_n;
      r_k         <= w_k_n;
      r_alu_sel   <= w_sel_n;
      r_alu_eleIn <= w_eleIn_n;
      r_out_valid <= w_ov_n;
      r_out_data  <= w_od_n;
      r_out_last  <= w_ol_n;
      r_cmd_err   <= w_err_n;
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign in_ready  = w_in_ready;
  assign cmd_err   = r_cmd_err;
  assign alu_sel   = r_alu_sel;
  assign alu_eleIn = r_alu_eleIn;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_alu_mat_driver.sv
// Bench for alu_mat_driver paired with a behavioural 3x3 matrix ALU; results
// are checked against a scoreboard queue filled when each command is issued.
`timescale 1ns/1ps
module tb_alu_mat_driver;

  localparam int DW = 32;
  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic          cmd_err;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [SW-1:0] alu_sel;
  logic [DW-1:0] alu_eleIn;
  logic [DW-1:0] alu_eleOut;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  always #5 clk = ~clk;

  alu_mat_driver #(.DATA_W(DW), .SEL_W(SW), .IDLE_SEL(27), .C_SEL(40)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_err(cmd_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .alu_sel(alu_sel), .alu_eleIn(alu_eleIn), .alu_eleOut(alu_eleOut),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  // Behavioural matrix ALU on the sel/eleIn/eleOut port.
  logic [DW-1:0] m_e [9];
  logic [DW-1:0] m_f [9];
  logic [DW-1:0] m_r [9];
  logic [DW-1:0] m_c;
  logic [DW-1:0] m_det;

  function automatic logic [DW-1:0] mul_el(input int i, input int j);
    return m_e[i*3]*m_f[j] + m_e[i*3+1]*m_f[3+j] + m_e[i*3+2]*m_f[6+j];
  endfunction

  function automatic logic [DW-1:0] det_e();
    return m_e[0]*(m_e[4]*m_e[8] - m_e[5]*m_e[7])
         - m_e[1]*(m_e[3]*m_e[8] - m_e[5]*m_e[6])
         + m_e[2]*(m_e[3]*m_e[7] - m_e[4]*m_e[6]);
  endfunction

  always @(posedge clk) begin
    int s;
    s = int'(alu_sel);
    if (s < 9) m_e[s] <= alu_eleIn;
    else if (s < 18) m_f[s-9] <= alu_eleIn;
    else if (s == 40) m_c <= alu_eleIn;
    else if (s == 33) m_det <= det_e();
    else if (s >= 28 && s <= 32) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          case (s)
            28: m_r[i*3+j] <= m_e[j*3+i];
            29: m_r[i*3+j] <= m_e[i*3+j] + m_f[i*3+j];
            30: m_r[i*3+j] <= m_e[i*3+j] - m_f[i*3+j];
            31: m_r[i*3+j] <= mul_el(i, j);
            default: m_r[i*3+j] <= m_e[i*3+j] * m_c;
          endcase
    end
  end

  always_comb begin
    alu_eleOut = '0;
    if (alu_sel >= 6'd18 && alu_sel <= 6'd26) alu_eleOut = m_r[int'(alu_sel) - 18];
    else if (alu_sel == 6'd27) alu_eleOut = m_det;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  typedef struct { logic [DW-1:0] d; logic l; } exp_t;
  exp_t q[$];

  // Monitor: scoreboard pop, stall-hold checks, timing observations.
  int            cyc = 0;
  int            last_in_cyc = 0;
  int            lat_ov = -1;
  int            mul_lat = -1;
  int            n_csel = 0;
  int            n_mul = 0;
  bit            arm_ov = 0;
  bit            stalled = 0;
  logic [DW-1:0] stall_data = '0;
  logic          stall_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (in_valid && in_ready) begin
      last_in_cyc = cyc;
      arm_ov = 1;
    end
    if (alu_sel == 6'd40) n_csel++;
    if (alu_sel == 6'd31) begin
      n_mul++;
      mul_lat = cyc - last_in_cyc;
    end
    if (out_valid && arm_ov) begin
      lat_ov = cyc - last_in_cyc;
      arm_ov = 0;
    end
    if (stalled) begin
      chk("hold_valid", {31'd0, out_valid}, 1);
      chk("hold_data", out_data, stall_data);
      chk("hold_last", {31'd0, out_last}, {31'd0, stall_last});
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_word", out_data, '1);
      else begin
        e = q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_last", {31'd0, out_last}, {31'd0, e.l});
      end
    end
    stalled    = out_valid && !out_ready;
    stall_data = out_data;
    stall_last = out_last;
  end

  logic [DW-1:0] ea [9];
  logic [DW-1:0] fa [9];
  logic [DW-1:0] xa [9];

  task automatic push_x(input int n);
    for (int i = 0; i < n; i++) q.push_back('{d: xa[i], l: (i == n-1)});
  endtask

  task automatic do_cmd(input logic [2:0] op);
    bit ok = 0;
    int n = 0;
    cmd_op = op;
    cmd_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk); ok = cmd_ready;
      @(posedge clk); #1; n++;
    end
    cmd_valid = 1'b0;
    if (!ok) chk("cmd_timeout", 0, 1);
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    bit ok = 0;
    int n = 0;
    in_data = d;
    in_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; n++;
    end
    if (!ok) chk("in_timeout", 0, 1);
  endtask

  task automatic send_mats(input bit use_f, input int nf);
    for (int i = 0; i < 9; i++) send_word(ea[i]);
    if (use_f) for (int i = 0; i < nf; i++) send_word(fa[i]);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 300);
    chk(tag, {31'd0, busy}, 0);
    chk({tag, "_qempty"}, q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=%0d exp=0", cyc);
    $fatal(1);
  end

  initial begin
    int base;
    reset = 1'b1; cmd_valid = 0; cmd_op = 0; in_valid = 0; in_data = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_sel", {26'd0, alu_sel}, 27);
    chk("rst_eleIn", alu_eleIn, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cmd_err", {31'd0, cmd_err}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    @(posedge clk); #1;

    // Transpose
    for (int i = 0; i < 9; i++) ea[i] = i + 1;
    xa = '{1, 4, 7, 2, 5, 8, 3, 6, 9};
    push_x(9);
    do_cmd(3'd0);
    send_mats(0, 0);
    wait_idle("trn_idle");
    chk("trn_latency", lat_ov, 5);

    // Scale by 3
    base = n_csel;
    for (int i = 0; i < 9; i++) xa[i] = 3 * (i + 1);
    push_x(9);
    do_cmd(3'd4);
    send_mats(0, 0);
    send_word(3);
    in_valid = 1'b0;
    wait_idle("scl_idle");
    chk("scl_csel_cycles", n_csel - base, 1);
    chk("scl_latency", lat_ov, 5);

    // Multiply by identity
    base = n_mul;
    fa = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    for (int i = 0; i < 9; i++) xa[i] = i + 1;
    push_x(9);
    do_cmd(3'd3);
    send_mats(1, 9);
    wait_idle("mul_idle");
    chk("mul_sel_cycles", n_mul - base, 1);
    chk("mul_sel_delay", mul_lat, 2);

    // Determinant of diag(2,3,4)
    ea = '{2, 0, 0, 0, 3, 0, 0, 0, 4};
    xa[0] = 24;
    push_x(1);
    do_cmd(3'd5);
    send_mats(0, 0);
    wait_idle("det_idle");

    // Add with a 5-cycle sink stall on the first result word
    for (int i = 0; i < 9; i++) begin ea[i] = i + 1; fa[i] = i + 10; xa[i] = 2*i + 11; end
    push_x(9);
    out_ready = 1'b0;
    do_cmd(3'd1);
    send_mats(1, 9);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("stall_reach_valid", {31'd0, out_valid}, 1);
    end
    repeat (5) @(posedge clk);
    #1 chk("stall_valid_held", {31'd0, out_valid}, 1);
    chk("stall_q_intact", q.size(), 9);
    out_ready = 1'b1;
    wait_idle("add_idle");

    // Subtract with random operands
    for (int i = 0; i < 9; i++) begin
      ea[i] = $urandom_range(0, 5000);
      fa[i] = $urandom_range(0, 5000);
      xa[i] = ea[i] - fa[i];
    end
    push_x(9);
    do_cmd(3'd2);
    send_mats(1, 9);
    wait_idle("sub_idle");

    // Reset after 4 F words aborts the command
    for (int i = 0; i < 9; i++) begin ea[i] = i + 1; fa[i] = 1; end
    do_cmd(3'd3);
    send_mats(1, 4);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_out_valid", {31'd0, out_valid}, 0);
    chk("abort_in_ready", {31'd0, in_ready}, 0);
    chk("abort_sel", {26'd0, alu_sel}, 27);
    @(posedge clk); #1;

    // Illegal op
    do_cmd(3'd6);
    @(negedge clk);
    chk("ill_err_pulse", {31'd0, cmd_err}, 1);
    chk("ill_in_ready", {31'd0, in_ready}, 0);
    chk("ill_busy", {31'd0, busy}, 0);
    @(negedge clk);
    chk("ill_err_clear", {31'd0, cmd_err}, 0);
    chk("ill_in_ready2", {31'd0, in_ready}, 0);
    @(posedge clk); #1;

    // Still functional afterwards: det of diag(5,1,2)
    ea = '{5, 0, 0, 0, 1, 0, 0, 0, 2};
    xa[0] = 10;
    push_x(1);
    do_cmd(3'd5);
    send_mats(0, 0);
    wait_idle("det2_idle");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
